// File: rtl/ucpd_phy_pkg.sv
// Shared types for the UCPD PHY sequencer: controller states, Rp current codes
// and the comparator-to-CC-level encoder.
package ucpd_phy_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_DETECT   = 3'd2,
        ST_ATTACHED = 3'd3,
        ST_TX       = 3'd4
    } phy_state_t;

    localparam logic [1:0] RP_500MA  = 2'b00;
    localparam logic [1:0] RP_1500MA = 2'b01;
    localparam logic [1:0] RP_3000MA = 2'b10;
    localparam logic [1:0] RP_RSVD   = 2'b11;

    // CC level is the index of the highest asserted comparator plus one; 0 means open.
    function automatic logic [2:0] encode_vstate(input logic [3:0] cmp);
        logic [2:0] vs;
        vs = 3'd0;
        if (cmp[3])      vs = 3'd4;
        else if (cmp[2]) vs = 3'd3;
        else if (cmp[1]) vs = 3'd2;
        else if (cmp[0]) vs = 3'd1;
        return vs;
    endfunction

endpackage

// File: rtl/ucpd_cc_debounce.sv
// Comparator synchronizer, CC level encoder and the counter shared between the
// post-power-up settle delay and the CC debounce.
module ucpd_cc_debounce
    import ucpd_phy_pkg::*;
#(
    parameter int SETTLE_CYC   = 16,
    parameter int DEBOUNCE_CYC = 8,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       srst_n,
    input  logic [3:0] compout,
    input  logic       settle,
    input  logic       run,
    input  logic       clr,
    output logic       settle_done,
    output logic       acc_stb,
    output logic [2:0] acc_vstate
);

    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_HOLD = CNT_W'(DEBOUNCE_CYC);

    logic [3:0]       sync_q;
    logic [2:0]       sample;
    logic [2:0]       prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             match;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [1:0] ff_reg;
            always_ff @(posedge clk) begin
                if (!srst_n) ff_reg <= 2'b00;
                else         ff_reg <= {ff_reg[0], compout[gi]};
            end
            assign sync_q[gi] = ff_reg[1];
        end
    endgenerate

    assign sample      = encode_vstate(sync_q);
    assign match       = (sample == prev_reg);
    assign settle_done = settle && (cnt_reg == SET_LAST);
    // Strobe is combinational so the sequencer's registered outputs land on the accept edge.
    assign acc_stb     = run && match && (cnt_reg == DEB_LAST);
    assign acc_vstate  = sample;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr)
            cnt_next = '0;
        else if (settle)
            cnt_next = cnt_reg + 1'b1;
        else if (run) begin
            if (!match)
                cnt_next = '0;
            else if (cnt_reg < DEB_HOLD)
                cnt_next = cnt_reg + 1'b1;
        end else
            cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_reg  <= '0;
            prev_reg <= 3'd0;
        end else begin
            cnt_reg <= cnt_next;
            if (clr || (!settle && !run)) prev_reg <= 3'd0;
            else if (run)                 prev_reg <= sample;
        end
    end

endmodule

// File: rtl/ucpd_phy_seq.sv
// UCPD analog PHY sequencer: power-up, pull selection, CC attach/detach
// tracking and RX/TX switching. All outputs are registered from the next state.
module ucpd_phy_seq
    import ucpd_phy_pkg::*;
#(
    parameter int SETTLE_CYC   = 16,
    parameter int DEBOUNCE_CYC = 8,
    parameter int CNT_W        = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       ucpd_en,
    input  logic       src_mode,
    input  logic [1:0] rp_sel,
    input  logic [3:0] compout,
    input  logic       tx_req,
    input  logic       tx_done,
    output logic       phy_en,
    output logic       phy_comen,
    output logic       phy_rxen,
    output logic       phy_deten,
    output logic       phy_txoen,
    output logic       set_c500ma,
    output logic       set_c1500ma,
    output logic       set_c3000ma,
    output logic       set_rd,
    output logic       tx_gnt,
    output logic       attached,
    output logic [2:0] cc_vstate,
    output logic       evt_attach,
    output logic       evt_detach
);

    phy_state_t state_reg;
    phy_state_t state_next;
    logic       src_q_reg;
    logic       src_chg;
    logic       cnt_clr;
    logic       settle_done;
    logic       acc_stb;
    logic [2:0] acc_vstate;
    logic       detach;
    logic       active_next;
    logic       cc_live_next;
    logic [3:0] pull_next;

    ucpd_cc_debounce #(
        .SETTLE_CYC  (SETTLE_CYC),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .clk        (pclk),
        .srst_n     (presetn),
        .compout    (compout),
        .settle     (state_reg == ST_SETTLE),
        .run        (phy_deten),
        .clr        (cnt_clr),
        .settle_done(settle_done),
        .acc_stb    (acc_stb),
        .acc_vstate (acc_vstate)
    );

    assign src_chg = (state_reg != ST_OFF) && (src_mode != src_q_reg);
    assign detach  = acc_stb && (acc_vstate == 3'd0);

    always_comb begin
        state_next = state_reg;
        if (!ucpd_en)
            state_next = ST_OFF;
        else if (src_chg)
            state_next = ST_SETTLE;
        else begin
            case (state_reg)
                ST_OFF:      state_next = ST_SETTLE;
                ST_SETTLE:   if (settle_done) state_next = ST_DETECT;
                ST_DETECT:   if (acc_stb && (acc_vstate != 3'd0)) state_next = ST_ATTACHED;
                ST_ATTACHED: begin
                    if (detach)      state_next = ST_DETECT;
                    else if (tx_req) state_next = ST_TX;
                end
                ST_TX: begin
                    if (detach)       state_next = ST_DETECT;
                    else if (tx_done) state_next = ST_ATTACHED;
                end
                default:     state_next = ST_OFF;
            endcase
        end
    end

    // The shared counter restarts on every entry to SETTLE (including a role change) and to DETECT.
    assign cnt_clr = ((state_next == ST_SETTLE) && ((state_reg != ST_SETTLE) || src_chg)) ||
                     ((state_next == ST_DETECT) && (state_reg != ST_DETECT));

    always_comb begin
        pull_next = 4'b0001;
        if (src_mode) begin
            case (rp_sel)
                RP_1500MA:         pull_next = 4'b0100;
                RP_3000MA:         pull_next = 4'b0010;
                RP_500MA, RP_RSVD: pull_next = 4'b1000;
                default:           pull_next = 4'b1000;
            endcase
        end
    end

    assign active_next  = (state_next != ST_OFF);
    assign cc_live_next = (state_next == ST_DETECT) || (state_next == ST_ATTACHED) ||
                          (state_next == ST_TX);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_reg   <= ST_OFF;
            src_q_reg   <= 1'b0;
            phy_en      <= 1'b0;
            phy_comen   <= 1'b0;
            phy_rxen    <= 1'b0;
            phy_deten   <= 1'b0;
            phy_txoen   <= 1'b0;
            set_c500ma  <= 1'b0;
            set_c1500ma <= 1'b0;
            set_c3000ma <= 1'b0;
            set_rd      <= 1'b0;
            tx_gnt      <= 1'b0;
            attached    <= 1'b0;
            cc_vstate   <= 3'd0;
            evt_attach  <= 1'b0;
            evt_detach  <= 1'b0;
        end else begin
            state_reg <= state_next;
            src_q_reg <= src_mode;
            phy_en    <= active_next;
            {set_c500ma, set_c1500ma, set_c3000ma, set_rd} <= active_next ? pull_next : 4'b0000;
            phy_deten <= cc_live_next;
            phy_comen <= (state_next == ST_ATTACHED) || (state_next == ST_TX);
            phy_rxen  <= (state_next == ST_ATTACHED);
            phy_txoen <= (state_next == ST_TX);
            tx_gnt    <= (state_next == ST_TX);
            attached  <= (state_next == ST_ATTACHED) || (state_next == ST_TX);
            if (!cc_live_next)
                cc_vstate <= 3'd0;
            else if (acc_stb)
                cc_vstate <= acc_vstate;
            evt_attach <= (state_reg == ST_DETECT) && (state_next == ST_ATTACHED);
            evt_detach <= ((state_reg == ST_ATTACHED) || (state_reg == ST_TX)) &&
                          (state_next == ST_DETECT);
        end
    end

endmodule

// File: tb/tb_ucpd_phy_seq.sv
// Directed table-driven bench for ucpd_phy_seq with SETTLE_CYC=16, DEBOUNCE_CYC=8.
module tb_ucpd_phy_seq;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       ucpd_en;
    logic       src_mode;
    logic [1:0] rp_sel;
    logic [3:0] compout;
    logic       tx_req;
    logic       tx_done;
    logic       phy_en, phy_comen, phy_rxen, phy_deten, phy_txoen;
    logic       set_c500ma, set_c1500ma, set_c3000ma, set_rd;
    logic       tx_gnt, attached, evt_attach, evt_detach;
    logic [2:0] cc_vstate;
    logic [15:0] act;

    int n_vec = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    ucpd_phy_seq #(.SETTLE_CYC(16), .DEBOUNCE_CYC(8), .CNT_W(16)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .ucpd_en    (ucpd_en),
        .src_mode   (src_mode),
        .rp_sel     (rp_sel),
        .compout    (compout),
        .tx_req     (tx_req),
        .tx_done    (tx_done),
        .phy_en     (phy_en),
        .phy_comen  (phy_comen),
        .phy_rxen   (phy_rxen),
        .phy_deten  (phy_deten),
        .phy_txoen  (phy_txoen),
        .set_c500ma (set_c500ma),
        .set_c1500ma(set_c1500ma),
        .set_c3000ma(set_c3000ma),
        .set_rd     (set_rd),
        .tx_gnt     (tx_gnt),
        .attached   (attached),
        .cc_vstate  (cc_vstate),
        .evt_attach (evt_attach),
        .evt_detach (evt_detach)
    );

    assign act = {phy_en, phy_comen, phy_rxen, phy_deten, phy_txoen,
                  set_c500ma, set_c1500ma, set_c3000ma, set_rd,
                  tx_gnt, attached, cc_vstate, evt_attach, evt_detach};

    localparam logic [15:0] B_EN  = 16'h8000;
    localparam logic [15:0] B_COM = 16'h4000;
    localparam logic [15:0] B_RX  = 16'h2000;
    localparam logic [15:0] B_DET = 16'h1000;
    localparam logic [15:0] B_TXO = 16'h0800;
    localparam logic [15:0] P500  = 16'h0400;
    localparam logic [15:0] P1500 = 16'h0200;
    localparam logic [15:0] P3000 = 16'h0100;
    localparam logic [15:0] PRD   = 16'h0080;
    localparam logic [15:0] B_GNT = 16'h0040;
    localparam logic [15:0] B_ATT = 16'h0020;
    localparam logic [15:0] V2    = 16'h0008;
    localparam logic [15:0] V3    = 16'h000C;
    localparam logic [15:0] B_EA  = 16'h0002;
    localparam logic [15:0] B_ED  = 16'h0001;
    localparam logic [15:0] SET   = B_EN;
    localparam logic [15:0] DET   = B_EN | B_DET;
    localparam logic [15:0] ATT   = DET | B_COM | B_RX | B_ATT;
    localparam logic [15:0] TXS   = DET | B_COM | B_TXO | B_GNT | B_ATT;

    typedef struct {
        string       name;
        logic        en;
        logic        src;
        logic [1:0]  rp;
        logic [3:0]  cmp;
        logic        req;
        logic        done;
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    task automatic add(inout vec_t q[$], input string nm, input logic en, input logic src,
                       input logic [1:0] rp, input logic [3:0] cmp, input logic req,
                       input logic done, input int n, input logic [15:0] exp);
        vec_t v;
        v.name = nm; v.en = en; v.src = src; v.rp = rp; v.cmp = cmp;
        v.req = req; v.done = done; v.n = n; v.exp = exp;
        q.push_back(v);
    endtask

    task automatic check(input string nm, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end else
            $display("ok   %s: %h", nm, act);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        ucpd_en  = v.en;
        src_mode = v.src;
        rp_sel   = v.rp;
        compout  = v.cmp;
        tx_req   = v.req;
        tx_done  = v.done;
        step(v.n);
        check(v.name, v.exp);
    endtask

    initial begin
        add(vecs_a, "settle_entry",  1, 1, 2'b01, 4'b0000, 0, 0,  1, SET | P1500);
        add(vecs_a, "settle_hold",   1, 1, 2'b01, 4'b0000, 0, 0, 15, SET | P1500);
        add(vecs_a, "detect_entry",  1, 1, 2'b01, 4'b0000, 0, 0,  1, DET | P1500);
        add(vecs_a, "detect_idle",   1, 1, 2'b01, 4'b0000, 0, 0,  3, DET | P1500);

        add(vecs_b, "attach_wait",   1, 1, 2'b01, 4'b0100, 0, 0, 10, DET | P1500);
        add(vecs_b, "attach_evt",    1, 1, 2'b01, 4'b0100, 0, 0,  1, ATT | P1500 | V3 | B_EA);
        add(vecs_b, "attach_hold",   1, 1, 2'b01, 4'b0100, 0, 0,  1, ATT | P1500 | V3);
        add(vecs_b, "rp_change",     1, 1, 2'b10, 4'b0100, 0, 0,  1, ATT | P3000 | V3);
        add(vecs_b, "tx_grant",      1, 1, 2'b01, 4'b0100, 1, 0,  1, TXS | P1500 | V3);
        add(vecs_b, "tx_hold",       1, 1, 2'b01, 4'b0100, 1, 0,  2, TXS | P1500 | V3);
        add(vecs_b, "tx_done",       1, 1, 2'b01, 4'b0100, 0, 1,  1, ATT | P1500 | V3);
        add(vecs_b, "tx_regrant",    1, 1, 2'b01, 4'b0100, 1, 0,  1, TXS | P1500 | V3);
        add(vecs_b, "tx_done_req",   1, 1, 2'b01, 4'b0100, 1, 1,  1, ATT | P1500 | V3);
        add(vecs_b, "tx_reenter",    1, 1, 2'b01, 4'b0100, 1, 0,  1, TXS | P1500 | V3);
        add(vecs_b, "detach_wait",   1, 1, 2'b01, 4'b0000, 1, 0, 10, TXS | P1500 | V3);
        add(vecs_b, "detach_evt",    1, 1, 2'b01, 4'b0000, 1, 0,  1, DET | P1500 | B_ED);
        add(vecs_b, "detach_hold",   1, 1, 2'b01, 4'b0000, 1, 0,  1, DET | P1500);
        add(vecs_b, "done_ignored",  1, 1, 2'b01, 4'b0000, 0, 1,  1, DET | P1500);
        add(vecs_b, "sink_restart",  1, 0, 2'b01, 4'b0000, 0, 0,  1, SET | PRD);
        add(vecs_b, "sink_settle",   1, 0, 2'b01, 4'b0000, 0, 0, 15, SET | PRD);
        add(vecs_b, "sink_detect",   1, 0, 2'b01, 4'b0000, 0, 0,  1, DET | PRD);
        add(vecs_b, "sink_att_wait", 1, 0, 2'b01, 4'b0010, 0, 0, 10, DET | PRD);
        add(vecs_b, "sink_att_evt",  1, 0, 2'b01, 4'b0010, 0, 0,  1, ATT | PRD | V2 | B_EA);
        add(vecs_b, "role_swap",     1, 1, 2'b11, 4'b0010, 0, 0,  1, SET | P500);
        add(vecs_b, "swap_settle",   1, 1, 2'b11, 4'b0010, 0, 0,  4, SET | P500);
        add(vecs_b, "abort",         0, 1, 2'b11, 4'b0010, 0, 0,  1, 16'h0000);
        add(vecs_b, "abort_hold",    0, 1, 2'b11, 4'b0010, 0, 0,  2, 16'h0000);
        add(vecs_b, "reenable",      1, 1, 2'b00, 4'b0010, 0, 0,  1, SET | P500);

        presetn  = 1'b0;
        ucpd_en  = 1'b1;
        src_mode = 1'b1;
        rp_sel   = 2'b01;
        compout  = 4'b0000;
        tx_req   = 1'b0;
        tx_done  = 1'b0;
        step(2);
        check("reset", 16'h0000);
        presetn = 1'b1;

        for (int i = 0; i < vecs_a.size(); i++) run_vec(vecs_a[i]);

        // Short CC pulse in DETECT must never be accepted.
        compout = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("glitch_hi", DET | P1500);
        end
        compout = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            step(1);
            check("glitch_lo", DET | P1500);
        end

        for (int i = 0; i < vecs_b.size(); i++) run_vec(vecs_b[i]);

        // Reset asserted mid-SETTLE, then released with the block still enabled.
        presetn = 1'b0;
        step(1);
        check("rst_mid", 16'h0000);
        presetn = 1'b1;
        step(1);
        check("rst_release", SET | P500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
